fpcvt_seq: RTL



---
 rtl/fpcvt_seq_if.sv | 26 ++
 rtl/fpcvt_seq.sv | 133 +++++++++++++
 2 files changed

// File: rtl/fpcvt_seq_if.sv
// Handshake bundle for fpcvt_seq: sample in over in_valid/in_ready, S/E/F/sat out over out_valid/out_ready.
interface fpcvt_seq_if #(
  parameter int DW = 12,
  parameter int EW = 3,
  parameter int FW = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] D;
  logic                 out_valid;
  logic                 out_ready;
  logic                 S;
  logic [EW-1:0]        E;
  logic [FW-1:0]        F;
  logic                 sat;

  modport master (
    output in_valid, D, out_ready,
    input  in_ready, out_valid, S, E, F, sat
  );

  modport slave (
    input  in_valid, D, out_ready,
    output in_ready, out_valid, S, E, F, sat
  );
endinterface

// File: rtl/fpcvt_seq.sv
// Sequential linear-to-float converter: normalises one bit per clock into S, E, F (value = F*2^E).
// FPCVT_ROUND_EN selects round-half-up on the last shifted-out bit; otherwise the significand is truncated.
module fpcvt_seq #(
  parameter int DW = 12,
  parameter int EW = 3,
  parameter int FW = 4
) (
  input  logic         clk,
  input  logic         rst,
  fpcvt_seq_if.slave   bus
);
  localparam logic [EW:0]          EMAX_C = (EW+1)'((1 << EW) - 1);
  localparam logic signed [DW-1:0] MINNEG = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] mag;
  logic [EW:0]   ecnt;
  logic          sgn;
  logic          minneg;
  logic          hi_nz;
  logic          s_q, sat_q;
  logic [EW-1:0] e_q;
  logic [FW-1:0] f_q;
  logic [EW:0]   e_rnd;
  logic [FW-1:0] f_rnd;
  logic          sat_rnd;
`ifdef FPCVT_ROUND_EN
  logic          rbit;
  logic [FW:0]   fr;
`endif

  // Most-negative input maps to 2^(DW-1), which still fits as an unsigned DW-bit magnitude.
  function automatic logic [DW-1:0] abs_mag(input logic signed [DW-1:0] x);
    logic signed [DW-1:0] n;
    n = -x;
    return x[DW-1] ? n : x;
  endfunction

`ifdef FPCVT_ROUND_EN
  function automatic logic [FW:0] round_frac(input logic [FW-1:0] m, input logic r);
    return {1'b0, m} + {{FW{1'b0}}, r};
  endfunction
`endif

  function automatic logic is_sat(input logic [EW:0] e, input logic mn);
    return (e > EMAX_C) || mn;
  endfunction

  assign hi_nz = |mag[DW-1:FW];

  always_comb begin
    e_rnd   = ecnt;
    f_rnd   = mag[FW-1:0];
`ifdef FPCVT_ROUND_EN
    fr = round_frac(mag[FW-1:0], rbit);
    if (fr[FW]) begin
      f_rnd = {1'b1, {(FW-1){1'b0}}};
      e_rnd = ecnt + (EW+1)'(1);
    end else begin
      f_rnd = fr[FW-1:0];
    end
`endif
    sat_rnd = is_sat(e_rnd, minneg);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = NORM;
      NORM:    if (!hi_nz)        state_nxt = ROUND;
      ROUND:                      state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag    <= '0;
      ecnt   <= '0;
      sgn    <= 1'b0;
      minneg <= 1'b0;
`ifdef FPCVT_ROUND_EN
      rbit   <= 1'b0;
`endif
      s_q    <= 1'b0;
      e_q    <= '0;
      f_q    <= '0;
      sat_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          sgn    <= bus.D[DW-1];
          mag    <= abs_mag(bus.D);
          ecnt   <= '0;
          minneg <= (bus.D == MINNEG);
`ifdef FPCVT_ROUND_EN
          rbit   <= 1'b0;
`endif
        end
        NORM: if (hi_nz) begin
          mag  <= mag >> 1;
          ecnt <= ecnt + (EW+1)'(1);
`ifdef FPCVT_ROUND_EN
          rbit <= mag[0];
`endif
        end
        // Result registers update only here, so DONE holds them stable under backpressure.
        ROUND: begin
          s_q   <= sgn;
          e_q   <= sat_rnd ? '1 : e_rnd[EW-1:0];
          f_q   <= sat_rnd ? '1 : f_rnd;
          sat_q <= sat_rnd;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.S         = s_q;
  assign bus.E         = e_q;
  assign bus.F         = f_q;
  assign bus.sat       = sat_q;
endmodule
